tab_table_loader: RTL
=====================

Name: tab_table_loader

Overview:
- Writer side of the tabulation-hash lookup tables: fills the 13 random tables (256 x 32 bit each) that the five-tuple hash path reads.
- Generates pseudo-random entries with an xorshift32 generator seeded by a host register, and streams them out over a valid/ready write port into the table RAMs.
- Asserts tables_valid only after a complete reload. Hash lookups are gated on tables_valid.

Parameters:
NUM_TABLES, 13, number of tables; one per five-tuple byte; wr_table width is 4 bits, so NUM_TABLES must be <= 16
ADDR_WIDTH, 8, entries per table = 2**ADDR_WIDTH
DEFAULT_SEED, 32'h2545F491, substitute seed used when seed input is 0

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  synchronous reset, active low
start  in  1  pulse/level; sampled only in IDLE; begins reload
abort  in  1  aborts reload in progress; has priority over every other event
seed  in  32  generator seed, captured when start is accepted
wr_ready  in  1  table RAM accepts write this cycle
wr_en  out  1  write valid
wr_table  out  4  target table index 0..NUM_TABLES-1
wr_addr  out  ADDR_WIDTH  entry index
wr_data  out  32  random entry
busy  out  1  high from start acceptance until done or abort
done  out  1  one-cycle pulse after last write accepted
tables_valid  out  1  tables fully loaded since last start

Behaviour:
- Reset: synchronous, active low, sampled on rising axi_aclk. All outputs reset to 0; FSM goes to IDLE; generator state is 0.
- Generator step, G(x): x ^= x<<13; x ^= x>>17; x ^= x<<5, all 32-bit truncated.
- FSM IDLE: start=1 -> LOAD. On that edge:
  - capture seed, using DEFAULT_SEED if seed==0;
  - clear tables_valid;
  - set busy=1;
  - clear table and address counters.
- FSM LOAD (1 cycle): state <= G(captured seed) -> WRITE.
- FSM WRITE:
  - wr_en=1, wr_data=state, with wr_table/wr_addr taken from the counters.
  - Handshake: a write transfers on a cycle where wr_en && wr_ready.
  - While wr_ready=0, wr_en, wr_table, wr_addr and wr_data hold stable.
  - On transfer: state <= G(state); wr_addr increments.
  - When wr_addr wraps 2**ADDR_WIDTH-1 -> 0, wr_table increments.
  - Transfer of table NUM_TABLES-1, addr 2**ADDR_WIDTH-1 -> DONE.
- FSM DONE (1 cycle): done=1, tables_valid<=1, busy<=0 -> IDLE.
- Write order: table-major, address-minor; NUM_TABLES * 2**ADDR_WIDTH = 3328 writes total.
- Latency with wr_ready tied high:
  - start sampled at edge 0;
  - wr_en high on cycles 2..3329 (3328 consecutive cycles);
  - done high on cycle 3330.
- start while busy: ignored, no restart. start in the DONE cycle is also ignored.
- abort in any state (including simultaneous with a transfer or with start):
  - next cycle FSM=IDLE, wr_en=0, busy=0, tables_valid=0, done not pulsed;
  - the partial write is discarded by definition.
- Reset mid-reload: same outputs as abort; all state is cleared.
- wr_ready ignored when wr_en=0.

Optional Feature:
TAB_LOADER_CHECKSUM_EN
- Defined: adds output port checksum[31:0]. It is the XOR of every transferred wr_data word since the last accepted start. It is cleared to 0 on start acceptance, reset and abort, and is stable and valid while tables_valid=1.
- Undefined: no checksum port or logic.

Test Plan:
- Seed 32'h00000001, wr_ready=1 -> first write table 0, addr 0, data 32'h00042021. Second write addr 1, data = G(32'h00042021). Exactly 3328 writes. done is a single pulse on cycle 3330; tables_valid=1 afterwards.
- seed=0 -> first wr_data = G(32'h2545F491); the write sequence is identical to a run with seed=32'h2545F491.
- wr_ready random 50% -> wr_en/wr_table/wr_addr/wr_data held stable while stalled. Data sequence is identical to the no-stall run; total transfers = 3328.
- Boundary: after 256 transfers, wr_table 0->1 and wr_addr 255->0. The last transfer is wr_table=12, wr_addr=255.
- abort asserted at write 1000 -> next cycle wr_en=0, busy=0, tables_valid=0, no done pulse. A following start with seed 1 restarts at table 0 addr 0, data 32'h00042021.
- axi_aresetn low for 1 cycle mid-reload -> all outputs 0 next cycle. start pulsed while busy -> no effect on the sequence. With TAB_LOADER_CHECKSUM_EN defined, checksum equals the XOR of the reference-model stream.

Source files
------------

// File: rtl/tab_table_loader.sv
// Writer for the tabulation-hash random tables: streams xorshift32 entries into
// NUM_TABLES x 2**ADDR_WIDTH words. Define TAB_LOADER_CHECKSUM_EN to add a checksum port.
module tab_table_loader #(
    parameter int          NUM_TABLES   = 13,
    parameter int          ADDR_WIDTH   = 8,
    parameter logic [31:0] DEFAULT_SEED = 32'h2545F491
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           seed,
    input  logic                  wr_ready,
    output logic                  wr_en,
    output logic [3:0]            wr_table,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
`ifdef TAB_LOADER_CHECKSUM_EN
    output logic [31:0]           checksum,
`endif
    output logic                  tables_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // wr_table is 4 bits wide, so NUM_TABLES must not exceed 16
    localparam logic [3:0]            TBL_LAST  = 4'(NUM_TABLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 5'd13);
        t = t ^ (t >> 5'd17);
        t = t ^ (t << 5'd5);
        return t;
    endfunction

    state_t                state_q, state_d;
    logic [31:0]           gen_q, gen_d;
    logic [3:0]            tbl_q, tbl_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tables_valid_q, tables_valid_d;
`ifdef TAB_LOADER_CHECKSUM_EN
    logic [31:0]           checksum_q, checksum_d;
`endif

    logic xfer_s;
    logic last_s;

    assign xfer_s = wr_en_q & wr_ready;
    assign last_s = (tbl_q == TBL_LAST) && (addr_q == ADDR_LAST);

    // Next-state logic; abort overrides every other event
    always_comb begin
        state_d        = state_q;
        gen_d          = gen_q;
        tbl_d          = tbl_q;
        addr_d         = addr_q;
        wr_en_d        = wr_en_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        tables_valid_d = tables_valid_q;
`ifdef TAB_LOADER_CHECKSUM_EN
        checksum_d     = checksum_q;
`endif
        if (abort) begin
            state_d        = ST_IDLE;
            gen_d          = 32'h0000_0000;
            tbl_d          = 4'd0;
            addr_d         = {ADDR_WIDTH{1'b0}};
            wr_en_d        = 1'b0;
            busy_d         = 1'b0;
            tables_valid_d = 1'b0;
`ifdef TAB_LOADER_CHECKSUM_EN
            checksum_d     = 32'h0000_0000;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d        = ST_LOAD;
                        gen_d          = (seed == 32'h0000_0000) ? DEFAULT_SEED : seed;
                        tbl_d          = 4'd0;
                        addr_d         = {ADDR_WIDTH{1'b0}};
                        busy_d         = 1'b1;
                        tables_valid_d = 1'b0;
`ifdef TAB_LOADER_CHECKSUM_EN
                        checksum_d     = 32'h0000_0000;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_WRITE;
                    gen_d   = xorshift32(gen_q);
                    wr_en_d = 1'b1;
                end
                ST_WRITE: begin
                    if (xfer_s) begin
                        gen_d = xorshift32(gen_q);
`ifdef TAB_LOADER_CHECKSUM_EN
                        checksum_d = checksum_q ^ gen_q;
`endif
                        if (last_s) begin
                            state_d = ST_DONE;
                            wr_en_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_ONE;
                            if (addr_q == ADDR_LAST) begin
                                tbl_d = tbl_q + 4'd1;
                            end else begin
                                tbl_d = tbl_q;
                            end
                        end
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
                ST_DONE: begin
                    state_d        = ST_IDLE;
                    tables_valid_d = 1'b1;
                    busy_d         = 1'b0;
                end
                default: begin
                    state_d        = ST_IDLE;
                    wr_en_d        = 1'b0;
                    busy_d         = 1'b0;
                    tables_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q        <= ST_IDLE;
            gen_q          <= 32'h0000_0000;
            tbl_q          <= 4'd0;
            addr_q         <= {ADDR_WIDTH{1'b0}};
            wr_en_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            tables_valid_q <= 1'b0;
`ifdef TAB_LOADER_CHECKSUM_EN
            checksum_q     <= 32'h0000_0000;
`endif
        end else begin
            state_q        <= state_d;
            gen_q          <= gen_d;
            tbl_q          <= tbl_d;
            addr_q         <= addr_d;
            wr_en_q        <= wr_en_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            tables_valid_q <= tables_valid_d;
`ifdef TAB_LOADER_CHECKSUM_EN
            checksum_q     <= checksum_d;
`endif
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_table     = tbl_q;
    assign wr_addr      = addr_q;
    assign wr_data      = gen_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign tables_valid = tables_valid_q;
`ifdef TAB_LOADER_CHECKSUM_EN
    assign checksum     = checksum_q;
`endif

endmodule
